instr_mem_responder: RTL and testbench

//  Synthesizable responder for the core's instruction-fetch interface (req/gnt/rvalid/rdata).

---
 rtl/instr_mem_pkg.sv | 13 +
 rtl/instr_mem_responder_if.sv | 21 ++
 rtl/instr_mem_resp_pipe.sv | 43 ++++
 rtl/instr_mem_responder.sv | 85 ++++++++
 tb/tb_instr_mem_responder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package instr_mem_pkg;

    localparam int INSTR_WORD_WIDTH = 32;
    localparam int MAX_LATENCY      = 4;

    typedef struct packed {
        logic                        valid;
        logic                        err;
        logic [INSTR_WORD_WIDTH-1:0] data;
    } instr_resp_t;

endpackage

// File: rtl/instr_mem_responder_if.sv
// Instruction-fetch bus (req/gnt/rvalid/rdata/err) between the core and the responder.
interface instr_mem_responder_if;

    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    modport master (
        output instr_req, instr_addr,
        input  instr_gnt, instr_rvalid, instr_rdata, instr_err
    );

    modport slave (
        input  instr_req, instr_addr,
        output instr_gnt, instr_rvalid, instr_rdata, instr_err
    );

endinterface

// File: rtl/instr_mem_resp_pipe.sv
// Fixed-latency response shift register; bubbles clear valid/err but keep the last data word.
module instr_mem_resp_pipe
    import instr_mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  instr_resp_t resp_i,
    output instr_resp_t resp_o
);

    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        instr_resp_t src;
        instr_resp_t stage_d;
        instr_resp_t stage_q;

        if (gi == 0) begin : g_head
            assign src = resp_i;
        end else begin : g_body
            assign src = g_stage[gi-1].stage_q;
        end

        always_comb begin
            stage_d = src;
            if (!src.valid) begin
                stage_d.err  = 1'b0;
                stage_d.data = stage_q.data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end
    end

    assign resp_o = g_stage[LATENCY-1].stage_q;

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: word RAM, program-load port, fixed-latency in-order responses.
// Define INSTR_MEM_ERR_EN to grant out-of-range fetches and answer them with err=1, rdata=0.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int          N_WORDS   = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          LATENCY   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_mem_responder_if.slave  instr_bus,
    input  logic                  stall_i,
    input  logic                  load_we_i,
    input  logic [31:0]           load_addr_i,
    input  logic [31:0]           load_wdata_i
);

    localparam int          IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [31:0] SPAN  = 32'(N_WORDS * 4);
`ifdef INSTR_MEM_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("instr_mem_responder: LATENCY must be 1..%0d", MAX_LATENCY);
    end

    logic [INSTR_WORD_WIDTH-1:0] mem_q [N_WORDS];

    logic [31:0]      fetch_off;
    logic [31:0]      load_off;
    logic             fetch_in_range;
    logic             load_in_range;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] load_idx;
    logic             gnt;
    instr_resp_t      resp_d;
    instr_resp_t      resp_q;

    // Subtracting first makes addresses below BASE_ADDR wrap high and fail the range test.
    assign fetch_off      = instr_bus.instr_addr - BASE_ADDR;
    assign load_off       = load_addr_i - BASE_ADDR;
    assign fetch_in_range = (fetch_off < SPAN);
    assign load_in_range  = (load_off < SPAN);
    assign fetch_idx      = fetch_off[IDX_W+1:2];
    assign load_idx       = load_off[IDX_W+1:2];

    assign gnt = !rst && instr_bus.instr_req && !stall_i && !load_we_i
                 && (fetch_in_range || ERR_EN);

    always_ff @(posedge clk) begin
        if (load_we_i && load_in_range) begin
            mem_q[load_idx] <= load_wdata_i;
        end
    end

    // Read is registered by the first pipe stage; a load never coincides with a grant.
    always_comb begin
        resp_d       = '0;
        resp_d.valid = gnt;
        resp_d.err   = ERR_EN && gnt && !fetch_in_range;
        if (gnt && fetch_in_range) begin
            resp_d.data = mem_q[fetch_idx];
        end
    end

    instr_mem_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk    (clk),
        .rst    (rst),
        .resp_i (resp_d),
        .resp_o (resp_q)
    );

    // Masking with rst keeps a response maturing in the reset cycle itself from escaping.
    assign instr_bus.instr_gnt    = gnt;
    assign instr_bus.instr_rvalid = resp_q.valid && !rst;
    assign instr_bus.instr_err    = resp_q.err && !rst;
    assign instr_bus.instr_rdata  = resp_q.data;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench: two responders (LATENCY 1 and 3) share one stimulus stream and one memory model.
module tb_instr_mem_responder;

    localparam int          NW   = 16;
    localparam logic [31:0] BASE = 32'h0;
`ifdef INSTR_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        stall = 1'b0;
    logic        we = 1'b0;
    logic [31:0] laddr = '0;
    logic [31:0] wdata = '0;

    always #5 clk = ~clk;

    instr_mem_responder_if bus1 ();
    instr_mem_responder_if bus3 ();

    assign bus1.instr_req  = req;
    assign bus1.instr_addr = addr;
    assign bus3.instr_req  = req;
    assign bus3.instr_addr = addr;

    instr_mem_responder #(.N_WORDS(NW), .BASE_ADDR(BASE), .LATENCY(1)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .instr_bus    (bus1),
        .stall_i      (stall),
        .load_we_i    (we),
        .load_addr_i  (laddr),
        .load_wdata_i (wdata)
    );

    instr_mem_responder #(.N_WORDS(NW), .BASE_ADDR(BASE), .LATENCY(3)) u_dut3 (
        .clk          (clk),
        .rst          (rst),
        .instr_bus    (bus3),
        .stall_i      (stall),
        .load_we_i    (we),
        .load_addr_i  (laddr),
        .load_wdata_i (wdata)
    );

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        q1[$];
    exp_t        q3[$];
    logic [31:0] mdl_mem [NW];
    logic [31:0] last_rd [2];
    logic        exp_gnt = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit in_rng(input logic [31:0] a);
        return (a - BASE) < 32'(NW * 4);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // Reference model: decides grant from the rules, queues the response each DUT owes.
    task automatic model_cycle();
        exp_t e;
        exp_gnt = !rst && req && !stall && !we && (in_rng(addr) || ERR_EN);
        if (rst) begin
            while (q1.size() > 0 && q1[q1.size()-1].due >= cyc) void'(q1.pop_back());
            while (q3.size() > 0 && q3[q3.size()-1].due >= cyc) void'(q3.pop_back());
        end
        if (exp_gnt) begin
            e.err  = !in_rng(addr);
            e.data = e.err ? 32'h0 : mdl_mem[word_of(addr)];
            e.due  = cyc + 1;
            q1.push_back(e);
            e.due  = cyc + 3;
            q3.push_back(e);
        end
        if (we && in_rng(laddr)) mdl_mem[word_of(laddr)] = wdata;
    endtask

    task automatic drive(input logic r, input logic [31:0] a, input logic st,
                         input logic w, input logic [31:0] la, input logic [31:0] wd,
                         input logic rs);
        @(posedge clk);
        #1;
        rst = rs; req = r; addr = a; stall = st; we = w; laddr = la; wdata = wd;
        model_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic check_port(input int w, input logic rv, input logic er, input logic [31:0] rd);
        exp_t e;
        bit   have;
        have = (w == 0) ? (q1.size() > 0) : (q3.size() > 0);
        if (have) e = (w == 0) ? q1[0] : q3[0];
        if (rv) begin
            n_cmp++;
            if (!have) begin
                n_bad++;
                $display("FAIL resp_unexpected L%0d cyc=%0d: got rvalid=1 rdata=%h, required no response",
                         w * 2 + 1, cyc, rd);
            end else begin
                if (w == 0) void'(q1.pop_front()); else void'(q3.pop_front());
                if (e.due != cyc || e.data !== rd || e.err !== er) begin
                    n_bad++;
                    $display("FAIL resp L%0d cyc=%0d: got rdata=%h err=%b, required cyc=%0d rdata=%h err=%b",
                             w * 2 + 1, cyc, rd, er, e.due, e.data, e.err);
                end
                last_rd[w] = rd;
            end
        end else begin
            if (have && e.due <= cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_missing L%0d cyc=%0d: got rvalid=0, required rdata=%h err=%b",
                         w * 2 + 1, cyc, e.data, e.err);
                if (w == 0) void'(q1.pop_front()); else void'(q3.pop_front());
            end
            if (!rst) begin
                n_cmp++;
                if (rd !== last_rd[w] || er !== 1'b0) begin
                    n_bad++;
                    $display("FAIL idle_hold L%0d cyc=%0d: got rdata=%h err=%b, required rdata=%h err=0",
                             w * 2 + 1, cyc, rd, er, last_rd[w]);
                end
            end else begin
                last_rd[w] = 32'h0;
            end
        end
    endtask

    // Monitor: samples on the falling edge, independent of the stimulus process.
    always @(negedge clk) begin
        n_cmp++;
        if (bus1.instr_gnt !== exp_gnt) begin
            n_bad++;
            $display("FAIL gnt L1 cyc=%0d addr=%h: got %b, required %b", cyc, addr, bus1.instr_gnt, exp_gnt);
        end
        n_cmp++;
        if (bus3.instr_gnt !== exp_gnt) begin
            n_bad++;
            $display("FAIL gnt L3 cyc=%0d addr=%h: got %b, required %b", cyc, addr, bus3.instr_gnt, exp_gnt);
        end
        check_port(0, bus1.instr_rvalid, bus1.instr_err, bus1.instr_rdata);
        check_port(1, bus3.instr_rvalid, bus3.instr_err, bus3.instr_rdata);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        cur_req;
        logic [31:0] cur_addr;
        logic        rs_r, st_r, we_r;
        logic [31:0] la_r;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;

        // Reset, then load the whole program space.
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0000_0033, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 32'h0000_0013, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 32'h00f0_0293, 1'b0);
        for (int i = 3; i < NW; i++) drive(1'b0, 32'h0, 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

        // Single fetch, then back-to-back.
        drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(4);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(4);

        // Load collides with fetch of the same word.
        drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 32'hdead_beef, 1'b0);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(4);

        // Out-of-range fetch held for five cycles.
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(4);

        // Reset one cycle after a grant, then refetch the surviving program.
        drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(4);
        drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(4);

        // Wait states with the request held.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(4);

        // Random traffic; an ungranted in-range request is held like the core would.
        cur_req  = 1'b0;
        cur_addr = 32'h0;
        for (int n = 0; n < 600; n++) begin
            if (!(cur_req && in_rng(cur_addr) && !exp_gnt)) begin
                cur_req  = ($urandom_range(0, 3) != 0);
                cur_addr = ($urandom_range(0, 9) == 0) ? 32'(32'h40 + 4 * $urandom_range(0, 15))
                                                       : 32'(4 * $urandom_range(0, NW - 1));
                if ($urandom_range(0, 19) == 0) cur_addr = 32'hffff_fffc;
                cur_addr = cur_addr | 32'($urandom_range(0, 3));
            end
            rs_r = ($urandom_range(0, 59) == 0);
            st_r = ($urandom_range(0, 4) == 0);
            we_r = !rs_r && ($urandom_range(0, 6) == 0);
            la_r = ($urandom_range(0, 7) == 0) ? 32'(32'h40 + 4 * $urandom_range(0, 7))
                                               : 32'(4 * $urandom_range(0, NW - 1));
            drive(cur_req, cur_addr, st_r, we_r, la_r, $urandom, rs_r);
        end

        idle(6);
        n_cmp++;
        if (q1.size() != 0 || q3.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d responses outstanding, required 0/0", q1.size(), q3.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
